// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the predictor-pipeline hazard controller:
// icodes, register/status codes, controller states and bundles.
package pipe_hazard_ctrl_pkg;

    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;

    // Status 0 marks a bubble slot.
    localparam logic [2:0] SBUB = 3'd0;
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'b00,
        CTRL_MEM_WAIT = 2'b01,
        CTRL_HALT     = 2'b10
    } ctrl_state_e;

    typedef struct packed {
        logic load_use;
        logic ret_pend;
        logic mispredict;
        logic exc;
    } hazard_t;

    typedef struct packed {
        logic f_stall;
        logic d_stall;
        logic d_bubble;
        logic e_bubble;
        logic m_stall;
        logic m_bubble;
        logic w_stall;
        logic w_bubble;
        logic mispredict;
    } pipe_ctrl_t;

    // Any status other than AOK or bubble is an exception.
    function automatic logic stat_exc(
        input logic [2:0] s
    );
        return !(s inside {SAOK, SBUB});
    endfunction

    // Statuses that retire the machine into HALT.
    function automatic logic stat_fatal(
        input logic [2:0] s
    );
        return s inside {SHLT, SADR, SINS};
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_detect.sv
// Combinational hazard-condition decode (load-use, ret, mispredict, exception).
// Ports: pipe-register icodes/regs/status in, hazard_t bundle out.
module pipe_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [3:0] D_icode_i,
    input  logic [3:0] d_srcA_i,
    input  logic [3:0] d_srcB_i,
    input  logic [3:0] E_icode_i,
    input  logic [3:0] E_dstM_i,
    input  logic [3:0] M_icode_i,
    input  logic       M_branch_taken_i,
    input  logic       M_Cnd_i,
    input  logic [2:0] m_stat_i,
    input  logic [2:0] W_stat_i,
    output hazard_t    hz_o
);

    logic e_is_load;
    logic dst_hit;

    assign e_is_load = E_icode_i inside {IMRMOVQ, IPOPQ};
    assign dst_hit   = (E_dstM_i == d_srcA_i) ||
                       (E_dstM_i == d_srcB_i);

    assign hz_o.load_use   = e_is_load &&
                             (E_dstM_i != RNONE) &&
                             dst_hit;
    assign hz_o.ret_pend   = (D_icode_i == IRET) ||
                             (E_icode_i == IRET) ||
                             (M_icode_i == IRET);
    assign hz_o.mispredict = (M_icode_i == IJXX) &&
                             (M_branch_taken_i != M_Cnd_i);
    assign hz_o.exc        = stat_exc(m_stat_i) ||
                             stat_exc(W_stat_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble scheduler with RUN/MEM_WAIT/HALT FSM and dmem watchdog.
// Ports: decode/exec/mem/wb fields, dmem req/ack in; stage controls,
// mispredict_o, timeout_o, ctrl_state_o out. PIPE_PERF_CNT_EN adds
// perf_stall_o/perf_mispred_o/perf_wait_o saturating counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
)
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] D_icode_i,
    input  logic [3:0] d_srcA_i,
    input  logic [3:0] d_srcB_i,
    input  logic [3:0] E_icode_i,
    input  logic [3:0] E_dstM_i,
    input  logic [3:0] M_icode_i,
    input  logic       M_branch_taken_i,
    input  logic       M_Cnd_i,
    input  logic [2:0] m_stat_i,
    input  logic [2:0] W_stat_i,
    input  logic       dmem_req_i,
    input  logic       dmem_ack_i,
    output logic       F_stall_o,
    output logic       D_stall_o,
    output logic       D_bubble_o,
    output logic       E_bubble_o,
    output logic       M_stall_o,
    output logic       M_bubble_o,
    output logic       W_stall_o,
    output logic       W_bubble_o,
    output logic       mispredict_o,
    output logic       timeout_o,
    output logic [1:0] ctrl_state_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_stall_o,
    output logic [CNT_W-1:0] perf_mispred_o,
    output logic [CNT_W-1:0] perf_wait_o
`endif
);

    localparam int WD_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'(MEM_TIMEOUT - 1);

    ctrl_state_e     state_q;
    logic [WD_W-1:0] wd_cnt_q;
    hazard_t         hz;
    pipe_ctrl_t      ctrl;
    logic            mem_wait;
    logic            w_fatal;
    logic            wd_fire;

    pipe_hazard_detect u_detect (
        .D_icode_i        (D_icode_i),
        .d_srcA_i         (d_srcA_i),
        .d_srcB_i         (d_srcB_i),
        .E_icode_i        (E_icode_i),
        .E_dstM_i         (E_dstM_i),
        .M_icode_i        (M_icode_i),
        .M_branch_taken_i (M_branch_taken_i),
        .M_Cnd_i          (M_Cnd_i),
        .m_stat_i         (m_stat_i),
        .W_stat_i         (W_stat_i),
        .hz_o             (hz)
    );

    assign mem_wait = dmem_req_i && !dmem_ack_i;
    assign w_fatal  = stat_fatal(W_stat_i);

    // The wait cycle spent in RUN counts as the first one,
    // so the Nth consecutive wait cycle sees count N-1.
    assign wd_fire = (state_q == CTRL_MEM_WAIT) &&
                     mem_wait &&
                     (wd_cnt_q == WD_LAST);

    always_comb begin
        ctrl = '0;
        if (!rst_n_i) begin
            ctrl = '0;
        end else if (state_q == CTRL_HALT) begin
            ctrl.f_stall  = 1'b1;
            ctrl.d_stall  = 1'b1;
            ctrl.e_bubble = 1'b1;
            ctrl.m_stall  = 1'b1;
            ctrl.w_stall  = 1'b1;
        end else if (mem_wait) begin
            // Hold the access in M; W drains to a bubble.
            ctrl.f_stall  = 1'b1;
            ctrl.d_stall  = 1'b1;
            ctrl.e_bubble = 1'b1;
            ctrl.m_stall  = 1'b1;
            ctrl.w_bubble = 1'b1;
        end else if (hz.exc) begin
            ctrl.m_bubble = 1'b1;
            ctrl.w_stall  = 1'b1;
        end else if (hz.mispredict) begin
            ctrl.d_bubble   = 1'b1;
            ctrl.e_bubble   = 1'b1;
            ctrl.mispredict = 1'b1;
        end else if (hz.load_use) begin
            // Also absorbs a pending ret: D must hold,
            // not be bubbled, while the load resolves.
            ctrl.f_stall  = 1'b1;
            ctrl.d_stall  = 1'b1;
            ctrl.e_bubble = 1'b1;
        end else if (hz.ret_pend) begin
            ctrl.f_stall  = 1'b1;
            ctrl.d_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= CTRL_RUN;
            wd_cnt_q <= '0;
        end else begin
            unique case (state_q)
                CTRL_RUN: begin
                    if (w_fatal) begin
                        state_q <= CTRL_HALT;
                    end else if (mem_wait) begin
                        state_q  <= CTRL_MEM_WAIT;
                        wd_cnt_q <= WD_W'(1);
                    end
                end
                CTRL_MEM_WAIT: begin
                    if (w_fatal) begin
                        state_q  <= CTRL_HALT;
                        wd_cnt_q <= '0;
                    end else if (dmem_ack_i || !dmem_req_i) begin
                        // Ack completes; a dropped req abandons.
                        state_q  <= CTRL_RUN;
                        wd_cnt_q <= '0;
                    end else if (wd_fire) begin
                        state_q  <= CTRL_HALT;
                        wd_cnt_q <= '0;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + WD_W'(1);
                    end
                end
                CTRL_HALT: begin
                    state_q <= CTRL_HALT;
                end
                default: begin
                    state_q  <= CTRL_HALT;
                    wd_cnt_q <= '0;
                end
            endcase
        end
    end

    assign F_stall_o    = ctrl.f_stall;
    assign D_stall_o    = ctrl.d_stall;
    assign D_bubble_o   = ctrl.d_bubble;
    assign E_bubble_o   = ctrl.e_bubble;
    assign M_stall_o    = ctrl.m_stall;
    assign M_bubble_o   = ctrl.m_bubble;
    assign W_stall_o    = ctrl.w_stall;
    assign W_bubble_o   = ctrl.w_bubble;
    assign mispredict_o = ctrl.mispredict;
    assign timeout_o    = rst_n_i && wd_fire;
    assign ctrl_state_o = state_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_q;
    logic [CNT_W-1:0] perf_mispred_q;
    logic [CNT_W-1:0] perf_wait_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_stall_q   <= '0;
            perf_mispred_q <= '0;
            perf_wait_q    <= '0;
        end else if (state_q != CTRL_HALT) begin
            if (ctrl.f_stall && !(&perf_stall_q))
                perf_stall_q <= perf_stall_q + 1'b1;
            if (ctrl.mispredict && !(&perf_mispred_q))
                perf_mispred_q <= perf_mispred_q + 1'b1;
            if ((state_q == CTRL_MEM_WAIT) &&
                !(&perf_wait_q))
                perf_wait_q <= perf_wait_q + 1'b1;
        end
    end

    assign perf_stall_o   = perf_stall_q;
    assign perf_mispred_o = perf_mispred_q;
    assign perf_wait_o    = perf_wait_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push
// expected control words, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam logic [3:0] INOP = 4'h1;

    // {F_s,D_s,D_b,E_b, M_s,M_b,W_s,W_b, mp,to,state[1:0]}
    localparam logic [11:0] X_IDLE  = 12'b0000_0000_0000;
    localparam logic [11:0] X_IDLEW = 12'b0000_0000_0001;
    localparam logic [11:0] X_LU    = 12'b1101_0000_0000;
    localparam logic [11:0] X_RET   = 12'b1010_0000_0000;
    localparam logic [11:0] X_MP    = 12'b0011_0000_1000;
    localparam logic [11:0] X_EXC   = 12'b0000_0110_0000;
    localparam logic [11:0] X_WAIT0 = 12'b1101_1001_0000;
    localparam logic [11:0] X_WAIT1 = 12'b1101_1001_0001;
    localparam logic [11:0] X_TOUT  = 12'b1101_1001_0101;
    localparam logic [11:0] X_HALT  = 12'b1101_1010_0010;

    typedef struct {
        string       nm;
        logic [11:0] exp;
    } sb_t;

    logic       clk = 1'b1;
    logic       rst_n;
    logic [3:0] D_icode, d_srcA, d_srcB;
    logic [3:0] E_icode, E_dstM, M_icode;
    logic       M_taken, M_Cnd;
    logic [2:0] m_stat, W_stat;
    logic       dmem_req, dmem_ack;
    logic       F_stall, D_stall, D_bubble, E_bubble;
    logic       M_stall, M_bubble, W_stall, W_bubble;
    logic       mispredict, timeout;
    logic [1:0] ctrl_state;

    sb_t q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .D_icode_i        (D_icode),
        .d_srcA_i         (d_srcA),
        .d_srcB_i         (d_srcB),
        .E_icode_i        (E_icode),
        .E_dstM_i         (E_dstM),
        .M_icode_i        (M_icode),
        .M_branch_taken_i (M_taken),
        .M_Cnd_i          (M_Cnd),
        .m_stat_i         (m_stat),
        .W_stat_i         (W_stat),
        .dmem_req_i       (dmem_req),
        .dmem_ack_i       (dmem_ack),
        .F_stall_o        (F_stall),
        .D_stall_o        (D_stall),
        .D_bubble_o       (D_bubble),
        .E_bubble_o       (E_bubble),
        .M_stall_o        (M_stall),
        .M_bubble_o       (M_bubble),
        .W_stall_o        (W_stall),
        .W_bubble_o       (W_bubble),
        .mispredict_o     (mispredict),
        .timeout_o        (timeout),
        .ctrl_state_o     (ctrl_state)
    );

    // Monitor: the DUT presents a control word every cycle.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            sb_t e;
            logic [11:0] got;
            e   = q.pop_front();
            got = {F_stall, D_stall, D_bubble, E_bubble,
                   M_stall, M_bubble, W_stall, W_bubble,
                   mispredict, timeout, ctrl_state};
            n_tests++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b",
                         e.nm, got, e.exp);
            end
        end
    end

    task automatic idle();
        D_icode  = INOP;
        d_srcA   = RNONE;
        d_srcB   = RNONE;
        E_icode  = INOP;
        E_dstM   = RNONE;
        M_icode  = INOP;
        M_taken  = 1'b0;
        M_Cnd    = 1'b0;
        m_stat   = SAOK;
        W_stat   = SAOK;
        dmem_req = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic apply(input string nm,
                         input logic [11:0] exp);
        sb_t e;
        e.nm  = nm;
        e.exp = exp;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_n   = 1'b0;
        E_icode = IMRMOVQ;
        E_dstM  = 4'h3;
        d_srcA  = 4'h3;
        apply("reset_lu", X_IDLE);
        dmem_req = 1'b1;
        apply("reset_req", X_IDLE);
        rst_n = 1'b1;
        idle();
        apply("idle", X_IDLE);

        // Load-use
        E_icode = IMRMOVQ; E_dstM = 4'h3; d_srcA = 4'h3;
        apply("lu_mrm", X_LU);
        idle();
        apply("lu_clear", X_IDLE);
        E_icode = IPOPQ; E_dstM = 4'h5; d_srcB = 4'h5;
        apply("lu_pop", X_LU);
        idle();
        E_icode = IMRMOVQ;
        apply("lu_rnone", X_IDLE);
        E_dstM = 4'h3; d_srcA = 4'h4; d_srcB = 4'h2;
        apply("lu_nomatch", X_IDLE);

        // Ret walking D -> E -> M
        idle();
        D_icode = IRET;
        apply("ret_d", X_RET);
        D_icode = INOP; E_icode = IRET;
        apply("ret_e", X_RET);
        E_icode = INOP; M_icode = IRET;
        apply("ret_m", X_RET);
        idle();
        apply("ret_done", X_IDLE);
        D_icode = IRET;
        E_icode = IMRMOVQ; E_dstM = 4'h3; d_srcA = 4'h3;
        apply("lu_ret", X_LU);

        // Mispredict
        idle();
        M_icode = IJXX; M_taken = 1'b1; M_Cnd = 1'b0;
        apply("mp_tn", X_MP);
        M_taken = 1'b0; M_Cnd = 1'b1;
        apply("mp_nt", X_MP);
        M_taken = 1'b1;
        apply("mp_ok", X_IDLE);
        D_icode = IRET; M_Cnd = 1'b0;
        apply("mp_ret", X_MP);

        // Exceptions
        idle();
        m_stat = SADR;
        apply("exc_m", X_EXC);
        M_icode = IJXX; M_taken = 1'b1;
        apply("exc_mp", X_EXC);
        idle();
        m_stat = SBUB; W_stat = SBUB;
        apply("stat_bub", X_IDLE);

        // Memory wait with ack
        idle();
        dmem_req = 1'b1;
        apply("wait1", X_WAIT0);
        apply("wait2", X_WAIT1);
        apply("wait3", X_WAIT1);
        dmem_ack = 1'b1;
        apply("ack", X_IDLEW);
        idle();
        apply("after_ack", X_IDLE);
        dmem_ack = 1'b1;
        apply("ack_norq", X_IDLE);
        idle();
        apply("ack_norq2", X_IDLE);

        // Abandoned request
        dmem_req = 1'b1;
        apply("ab1", X_WAIT0);
        apply("ab2", X_WAIT1);
        dmem_req = 1'b0;
        apply("ab3", X_IDLEW);
        apply("ab4", X_IDLE);

        // Async reset mid-wait
        dmem_req = 1'b1;
        apply("rw1", X_WAIT0);
        apply("rw2", X_WAIT1);
        rst_n = 1'b0;
        apply("rw_rst", X_IDLE);
        rst_n = 1'b1;
        idle();
        apply("rw_run", X_IDLE);

        // Wait outranks exception
        dmem_req = 1'b1; m_stat = SADR;
        apply("wait_exc", X_WAIT0);
        idle();
        apply("wx_ab", X_IDLEW);
        apply("wx_run", X_IDLE);

        // Watchdog: fires on the 16th wait cycle
        dmem_req = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            if (i == 1)
                apply("to_w1", X_WAIT0);
            else if (i == 16)
                apply("to_fire", X_TOUT);
            else
                apply("to_wait", X_WAIT1);
        end
        apply("to_halt", X_HALT);
        idle();
        apply("halt_idle", X_HALT);
        dmem_req = 1'b1; dmem_ack = 1'b1;
        apply("halt_ack", X_HALT);
        rst_n = 1'b0;
        apply("halt_rst", X_IDLE);
        rst_n = 1'b1;
        idle();
        apply("post_rst", X_IDLE);

        // W halt while ret sits in D
        D_icode = IRET; W_stat = SHLT;
        apply("shlt_exc", X_EXC);
        apply("shlt_halt", X_HALT);
        idle();
        apply("shlt_stay", X_HALT);
        rst_n = 1'b0;
        apply("shlt_rst", X_IDLE);
        rst_n = 1'b1;
        apply("final", X_IDLE);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d left, need 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
